// File: rtl/vu_wb_pkg.sv
// Shared types and helpers for the vector register-file write-back scheduler.
package vu_wb_pkg;

  localparam int VREG_W   = 5;
  localparam int NUM_VREG = 32;

  typedef struct packed {
    logic [VREG_W-1:0] rnum;
    logic [1:0]        bwe;
    logic              xpose;
  } ld_wr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DEFER,
    ST_STARVED
  } wb_state_e;

  function automatic logic [NUM_VREG-1:0] rnum_onehot(input logic [VREG_W-1:0] rnum);
    logic [NUM_VREG-1:0] oh;
    oh       = '0;
    oh[rnum] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vurf_ldq2.sv
// Compacting load-write FIFO: entry 0 is always the head, valid bits stay contiguous.
module vurf_ldq2
  import vu_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                push_i,
  input  ld_wr_t              push_data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                head_vld_nxt_o,
  output ld_wr_t              head_o,
  output logic [NUM_VREG-1:0] pend_o
);

  ld_wr_t           ent_q [DEPTH];
  ld_wr_t           ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic             placed;

  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    placed = 1'b0;
    if (pop_i) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_d[i] = ent_q[i+1];
      end
      vld_d = vld_q >> 1;
    end
    // Push lands in the first slot left free after any pop this cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i && !placed && !vld_d[i]) begin
        ent_d[i] = push_data_i;
        vld_d[i] = 1'b1;
        placed   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
    end
  end

  always_comb begin
    pend_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        pend_o = pend_o | rnum_onehot(ent_q[i].rnum);
      end
    end
  end

  assign full_o         = vld_q[DEPTH-1];
  assign empty_o        = !vld_q[0];
  assign head_vld_nxt_o = vld_d[0];
  assign head_o         = ent_q[0];

endmodule

// File: rtl/vurf_wr_sched.sv
// VRF write-port scheduler: datapath writes always win, load writes are buffered and deferred on collision.
// state | meaning: IDLE fifo empty | ISSUE head valid, not deferred | DEFER head deferred | STARVED defer count saturated
module vurf_wr_sched
  import vu_wb_pkg::*;
#(
  parameter int LDQ_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                dp_wr_en_i,
  input  logic [VREG_W-1:0]   dp_vd_i,
  input  logic                dp_div_type_i,
  input  logic [2:0]          dp_div_elem_i,
  input  logic                ld_req_i,
  output logic                ld_ack_o,
  input  logic [VREG_W-1:0]   ld_rnum_in_i,
  input  logic [1:0]          ld_bwe_in_i,
  input  logic                ld_xpose_in_i,
  output logic                wbv_wr_en_o,
  output logic [VREG_W-1:0]   vd_o,
  output logic                wb_div_type_o,
  output logic [2:0]          wb_div_elem_o,
  output logic [VREG_W-1:0]   ld_rnum_o,
  output logic [1:0]          bwe_o,
  output logic                xpose_o,
  output logic [NUM_VREG-1:0] ld_pend_o,
  output logic                dp_hold_o
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic        q_full;
  logic        q_empty;
  logic        q_head_vld_nxt;
  ld_wr_t      q_head;
  logic        q_push;
  logic        q_pop;

  ld_wr_t      ld_in;
  ld_wr_t      cand;
  logic        cand_vld;
  logic        collide;
  logic        issue;

  logic              wbv_q, wbv_d;
  logic [VREG_W-1:0] vd_q, vd_d;
  logic              div_type_q, div_type_d;
  logic [2:0]        div_elem_q, div_elem_d;
  logic [VREG_W-1:0] ld_rnum_q, ld_rnum_d;
  logic [1:0]        bwe_q, bwe_d;
  logic              xpose_q, xpose_d;
  logic [CNT_W-1:0]  defer_q, defer_d;
  wb_state_e         state_q, state_d;

  vurf_ldq2 #(
    .DEPTH (LDQ_DEPTH)
  ) u_ldq (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .push_i         (q_push),
    .push_data_i    (ld_in),
    .pop_i          (q_pop),
    .full_o         (q_full),
    .empty_o        (q_empty),
    .head_vld_nxt_o (q_head_vld_nxt),
    .head_o         (q_head),
    .pend_o         (ld_pend_o)
  );

  assign ld_ack_o = !q_full;

  // The head has priority; the incoming request is only a candidate when nothing is buffered.
  always_comb begin
    ld_in.rnum  = ld_rnum_in_i;
    ld_in.bwe   = ld_bwe_in_i;
    ld_in.xpose = ld_xpose_in_i;
    cand        = q_empty ? ld_in : q_head;
    cand_vld    = !q_empty || ld_req_i;
    collide     = cand_vld && dp_wr_en_i && (dp_vd_i == cand.rnum);
    issue       = cand_vld && !collide;
    q_pop       = !q_empty && issue;
    q_push      = ld_req_i && ld_ack_o && !(q_empty && issue);
  end

  always_comb begin
    defer_d = '0;
    if (!q_empty && collide) begin
      defer_d = (defer_q == CNT_MAX) ? CNT_MAX : defer_q + CNT_W'(1);
    end
  end

  always_comb begin
    wbv_d      = dp_wr_en_i;
    vd_d       = dp_vd_i;
    div_type_d = dp_div_type_i;
    div_elem_d = dp_div_elem_i;
    ld_rnum_d  = ld_rnum_q;
    xpose_d    = xpose_q;
    bwe_d      = '0;
    if (issue) begin
      ld_rnum_d = cand.rnum;
      bwe_d     = cand.bwe;
      xpose_d   = cand.xpose;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (q_head_vld_nxt) begin
      if (defer_d == CNT_MAX) begin
        state_d = ST_STARVED;
      end else if (defer_d != '0) begin
        state_d = ST_DEFER;
      end else begin
        state_d = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wbv_q      <= 1'b0;
      vd_q       <= '0;
      div_type_q <= 1'b0;
      div_elem_q <= '0;
      ld_rnum_q  <= '0;
      bwe_q      <= '0;
      xpose_q    <= 1'b0;
      defer_q    <= '0;
    end else begin
      wbv_q      <= wbv_d;
      vd_q       <= vd_d;
      div_type_q <= div_type_d;
      div_elem_q <= div_elem_d;
      ld_rnum_q  <= ld_rnum_d;
      bwe_q      <= bwe_d;
      xpose_q    <= xpose_d;
      defer_q    <= defer_d;
    end
  end

  assign wbv_wr_en_o   = wbv_q;
  assign vd_o          = vd_q;
  assign wb_div_type_o = div_type_q;
  assign wb_div_elem_o = div_elem_q;
  assign ld_rnum_o     = ld_rnum_q;
  assign bwe_o         = bwe_q;
  assign xpose_o       = xpose_q;
  assign dp_hold_o     = (state_q == ST_STARVED);

endmodule

// File: tb/tb_vurf_wr_sched.sv
// Scoreboard bench for vurf_wr_sched: a queue-level model predicts every write-back and the scoreboard state.
module tb_vurf_wr_sched;
  import vu_wb_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dp_wr_en = 1'b0;
  logic [4:0]  dp_vd = '0;
  logic        dp_div_type = 1'b0;
  logic [2:0]  dp_div_elem = '0;
  logic        ld_req = 1'b0;
  logic        ld_ack;
  logic [4:0]  ld_rnum_in = '0;
  logic [1:0]  ld_bwe_in = '0;
  logic        ld_xpose_in = 1'b0;
  logic        wbv_wr_en;
  logic [4:0]  vd;
  logic        wb_div_type;
  logic [2:0]  wb_div_elem;
  logic [4:0]  ld_rnum;
  logic [1:0]  bwe;
  logic        xpose;
  logic [31:0] ld_pend;
  logic        dp_hold;

  always #5 clk = ~clk;

  vurf_wr_sched #(
    .LDQ_DEPTH  (2),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .dp_wr_en_i    (dp_wr_en),
    .dp_vd_i       (dp_vd),
    .dp_div_type_i (dp_div_type),
    .dp_div_elem_i (dp_div_elem),
    .ld_req_i      (ld_req),
    .ld_ack_o      (ld_ack),
    .ld_rnum_in_i  (ld_rnum_in),
    .ld_bwe_in_i   (ld_bwe_in),
    .ld_xpose_in_i (ld_xpose_in),
    .wbv_wr_en_o   (wbv_wr_en),
    .vd_o          (vd),
    .wb_div_type_o (wb_div_type),
    .wb_div_elem_o (wb_div_elem),
    .ld_rnum_o     (ld_rnum),
    .bwe_o         (bwe),
    .xpose_o       (xpose),
    .ld_pend_o     (ld_pend),
    .dp_hold_o     (dp_hold)
  );

  typedef struct {int tag; logic [4:0] rnum; logic [1:0] bwe; logic xpose;} ld_exp_t;
  typedef struct {int tag; logic [4:0] vd; logic ty; logic [2:0] el;} dp_exp_t;
  typedef struct {int tag; logic [31:0] pend; logic hold;} st_exp_t;

  ld_exp_t exp_ld[$];
  dp_exp_t exp_dp[$];
  st_exp_t exp_st[$];
  ld_exp_t mq[$];
  int      m_defer = 0;
  int      edge_n = 0;
  int      n_assert = 0;
  int      n_fail = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // One cycle of stimulus: drive, check ld_ack, then let the model predict what the next edge produces.
  task automatic step(input logic rst, input logic dpw, input logic [4:0] dvd, input logic dty,
                      input logic [2:0] del, input logic lrq, input logic [4:0] lrn,
                      input logic [1:0] lbw, input logic lxp, output logic acc);
    ld_exp_t     inc;
    ld_exp_t     cand;
    logic        m_ack, have, coll, iss, byp;
    logic [31:0] pend;
    @(negedge clk);
    reset = rst; dp_wr_en = dpw; dp_vd = dvd; dp_div_type = dty; dp_div_elem = del;
    ld_req = lrq; ld_rnum_in = lrn; ld_bwe_in = lbw; ld_xpose_in = lxp;
    #1;
    acc = 1'b0;
    if (rst) begin
      mq.delete();
      m_defer = 0;
      exp_st.push_back('{tag: edge_n + 1, pend: 32'h0, hold: 1'b0});
      return;
    end
    m_ack = (mq.size() < 2);
    n_assert++;
    if (ld_ack !== m_ack) begin
      n_fail++;
      $display("FAIL ld_ack edge %0d: got %b want %b", edge_n, ld_ack, m_ack);
    end
    inc  = '{tag: 0, rnum: lrn, bwe: lbw, xpose: lxp};
    have = (mq.size() > 0) || lrq;
    cand = (mq.size() > 0) ? mq[0] : inc;
    coll = have && dpw && (cand.rnum == dvd);
    iss  = have && !coll;
    byp  = iss && (mq.size() == 0);
    if (iss) begin
      cand.tag = edge_n + 1;
      exp_ld.push_back(cand);
    end
    if ((mq.size() > 0) && coll) m_defer = (m_defer < STARVE_MAX) ? m_defer + 1 : STARVE_MAX;
    else m_defer = 0;
    acc = lrq && m_ack;
    if (iss && !byp) void'(mq.pop_front());
    if (acc && !byp) mq.push_back(inc);
    pend = '0;
    foreach (mq[k]) pend[mq[k].rnum] = 1'b1;
    if (dpw) exp_dp.push_back('{tag: edge_n + 1, vd: dvd, ty: dty, el: del});
    exp_st.push_back('{tag: edge_n + 1, pend: pend, hold: (m_defer == STARVE_MAX)});
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0, 2'd0, 1'b0, a);
  endtask

  // Monitor: compares whatever the DUT presents after each edge against the scoreboard queues.
  always @(posedge clk) begin
    st_exp_t s;
    ld_exp_t l;
    dp_exp_t d;
    #1;
    if (exp_st.size() > 0 && exp_st[0].tag == edge_n) begin
      s = exp_st.pop_front();
      n_assert++;
      if (ld_pend !== s.pend || dp_hold !== s.hold) begin
        n_fail++;
        $display("FAIL sb_state edge %0d: ld_pend=%h dp_hold=%b want ld_pend=%h dp_hold=%b",
                 edge_n, ld_pend, dp_hold, s.pend, s.hold);
      end
    end
    if (bwe !== 2'b00) begin
      n_assert++;
      if (exp_ld.size() > 0 && exp_ld[0].tag == edge_n) begin
        l = exp_ld.pop_front();
        if (ld_rnum !== l.rnum || bwe !== l.bwe || xpose !== l.xpose) begin
          n_fail++;
          $display("FAIL ld_issue edge %0d: rnum=%0d bwe=%b xpose=%b want rnum=%0d bwe=%b xpose=%b",
                   edge_n, ld_rnum, bwe, xpose, l.rnum, l.bwe, l.xpose);
        end
      end else begin
        n_fail++;
        $display("FAIL ld_unexpected edge %0d: rnum=%0d bwe=%b want no load", edge_n, ld_rnum, bwe);
      end
    end else if (exp_ld.size() > 0 && exp_ld[0].tag == edge_n) begin
      l = exp_ld.pop_front();
      n_assert++;
      n_fail++;
      $display("FAIL ld_missing edge %0d: bwe=%b want rnum=%0d bwe=%b", edge_n, bwe, l.rnum, l.bwe);
    end
    if (wbv_wr_en === 1'b1) begin
      n_assert++;
      if (exp_dp.size() > 0 && exp_dp[0].tag == edge_n) begin
        d = exp_dp.pop_front();
        if (vd !== d.vd || wb_div_type !== d.ty || wb_div_elem !== d.el) begin
          n_fail++;
          $display("FAIL dp_wr edge %0d: vd=%0d ty=%b el=%0d want vd=%0d ty=%b el=%0d",
                   edge_n, vd, wb_div_type, wb_div_elem, d.vd, d.ty, d.el);
        end
      end else begin
        n_fail++;
        $display("FAIL dp_unexpected edge %0d: vd=%0d want no write", edge_n, vd);
      end
    end else if (exp_dp.size() > 0 && exp_dp[0].tag == edge_n) begin
      d = exp_dp.pop_front();
      n_assert++;
      n_fail++;
      $display("FAIL dp_missing edge %0d: wbv_wr_en=%b want vd=%0d", edge_n, wbv_wr_en, d.vd);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic       done;
    logic       preq;
    logic       rst, dpw;
    logic [4:0] pr;
    logic [1:0] pb;
    logic       px;

    step(1'b1, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0, 2'd0, 1'b0, acc);
    step(1'b1, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0, 2'd0, 1'b0, acc);
    @(posedge clk); #2;
    n_assert++;
    if ({wbv_wr_en, vd, wb_div_type, wb_div_elem, ld_rnum, bwe, xpose, ld_pend, dp_hold} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: wbv=%b vd=%0d div=%b/%0d rnum=%0d bwe=%b xpose=%b pend=%h hold=%b want all 0",
               wbv_wr_en, vd, wb_div_type, wb_div_elem, ld_rnum, bwe, xpose, ld_pend, dp_hold);
    end

    // Bypass with no datapath write.
    step(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b1, 5'd5, 2'b11, 1'b0, acc);
    idle(2);
    // Same-cycle collision: datapath first, load one cycle later.
    step(1'b0, 1'b1, 5'd7, 1'b0, 3'd0, 1'b1, 5'd7, 2'b10, 1'b1, acc);
    idle(3);
    // Starvation: load to 3 kept behind repeated datapath writes to 3.
    step(1'b0, 1'b1, 5'd3, 1'b0, 3'd0, 1'b1, 5'd3, 2'b01, 1'b0, acc);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 5'd3, 1'b0, 3'd0, 1'b0, 5'd0, 2'd0, 1'b0, acc);
    idle(3);
    // Fill the FIFO, then hold the third request until it is acknowledged.
    step(1'b0, 1'b1, 5'd1, 1'b0, 3'd0, 1'b1, 5'd1, 2'b11, 1'b0, acc);
    step(1'b0, 1'b1, 5'd1, 1'b0, 3'd0, 1'b1, 5'd2, 2'b01, 1'b1, acc);
    step(1'b0, 1'b1, 5'd1, 1'b0, 3'd0, 1'b1, 5'd4, 2'b10, 1'b0, acc);
    done = acc;
    for (int i = 0; i < 10 && !done; i++) begin
      step(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b1, 5'd4, 2'b10, 1'b0, acc);
      done = acc;
    end
    if (!done) begin
      n_assert++;
      n_fail++;
      $display("FAIL held_req_ack: got no ack within 10 cycles want ack");
    end
    idle(4);
    // Divide write collides like any other datapath write.
    step(1'b0, 1'b1, 5'd9, 1'b1, 3'd3, 1'b1, 5'd9, 2'b11, 1'b0, acc);
    idle(3);
    // Reset with two buffered loads: they must never issue.
    step(1'b0, 1'b1, 5'd10, 1'b0, 3'd0, 1'b1, 5'd10, 2'b11, 1'b0, acc);
    step(1'b0, 1'b1, 5'd10, 1'b0, 3'd0, 1'b1, 5'd11, 2'b11, 1'b0, acc);
    step(1'b1, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0, 2'd0, 1'b0, acc);
    idle(4);

    preq = 1'b0; pr = '0; pb = 2'b01; px = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!preq && $urandom_range(0, 1) == 1) begin
        preq = 1'b1;
        pr   = 5'($urandom_range(0, 7));
        pb   = 2'($urandom_range(1, 3));
        px   = 1'($urandom_range(0, 1));
      end
      if (m_defer == STARVE_MAX) dpw = ($urandom_range(0, 9) == 0);
      else dpw = ($urandom_range(0, 9) < 6);
      step(rst, dpw, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           preq, pr, pb, px, acc);
      if (acc || rst) preq = 1'b0;
    end
    idle(6);
    @(posedge clk); #3;
    n_assert++;
    if (exp_ld.size() != 0 || exp_dp.size() != 0 || exp_st.size() != 0) begin
      n_fail++;
      $display("FAIL drain: ld=%0d dp=%0d st=%0d left want 0 0 0", exp_ld.size(), exp_dp.size(), exp_st.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
